moesi_mem_arbiter: RTL

Shares the single `shared_memory` request port between `NUM_REQ` requesters, which are the coherency-bus fill path and the per-core writeback paths. It arbitrates with rotating priority and holds each winning request stable on the memory port until memory accepts it. It records the requester ID of every outstanding read in an in-order tag FIFO so each memory read response reaches the requester that issued it. It sits between the requesters and `u_mem` in `moesi_top`, replacing the direct read-only `bus_valid` to `mem_req_valid` tie-off.

---
 rtl/moesi_mem_arbiter_if.sv | 46 ++++
 rtl/moesi_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/moesi_mem_arbiter_if.sv
// Bundle of requester, memory and status signals for moesi_mem_arbiter.
// The slave modport is the arbiter's own view; the master modport is the
// view of whatever surrounds it (requesters plus the memory model).
interface moesi_mem_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_write;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_ack;
    logic [NUM_REQ-1:0]                 resp_valid;
    logic [DATA_WIDTH-1:0]              resp_rdata;

    logic                               mem_req_valid;
    logic                               mem_req_write;
    logic [ADDR_WIDTH-1:0]              mem_req_addr;
    logic [DATA_WIDTH-1:0]              mem_req_wdata;
    logic                               mem_req_ready;
    logic                               mem_resp_valid;
    logic [DATA_WIDTH-1:0]              mem_resp_rdata;

    logic [CNT_W-1:0]                   outstanding;
    logic                               err_orphan;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output req_ack, resp_valid, resp_rdata,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output outstanding, err_orphan
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  req_ack, resp_valid, resp_rdata,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  outstanding, err_orphan
    );
endinterface

// File: rtl/moesi_mem_arbiter.sv
// Shares the single memory request port between NUM_REQ requesters with
// rotating priority, and routes read responses back through an in-order
// tag FIFO of requester IDs.
// Optional feature: define MOESI_MEM_ARB_WB_PRIO_EN to let eligible writes
// beat eligible reads (round-robin within each class).
// MAX_OUTSTANDING must be a power of 2 and at least 2.
module moesi_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    moesi_mem_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q;
    logic [ID_W-1:0]       grantId_q;
    logic [ID_W-1:0]       rrPtr_q;
    logic                  memReqValid_q;
    logic                  memReqWrite_q;
    logic [ADDR_WIDTH-1:0] memReqAddr_q;
    logic [DATA_WIDTH-1:0] memReqWdata_q;

    logic [ID_W-1:0]       tagMem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wrPtr_q;
    logic [PTR_W-1:0]      rdPtr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  errOrphan_q;

    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  accept;
    logic                  pushTag;
    logic                  popTag;
    logic                  orphanHit;
    logic [NUM_REQ-1:0]    eligible;
    logic                  winFound;
    logic [ID_W-1:0]       winId;
    logic [NUM_REQ-1:0]    reqAck;
    logic [NUM_REQ-1:0]    respValid;

    // Requester index offset steps above base, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] wrapIdx(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    assign fifoFull  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifoEmpty = (count_q == '0);
    assign accept    = (state_q == ISSUE) && bus.mem_req_ready;
    assign pushTag   = accept && !memReqWrite_q;
    assign popTag    = bus.mem_resp_valid && !fifoEmpty;
    assign orphanHit = bus.mem_resp_valid && fifoEmpty;
    assign eligible  = bus.req_valid & (bus.req_write | {NUM_REQ{!fifoFull}});

    // Pick the first eligible requester at or after the rotating pointer.
    always_comb begin
        winFound = 1'b0;
        winId    = '0;
`ifdef MOESI_MEM_ARB_WB_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winFound && eligible[wrapIdx(rrPtr_q, k)] && bus.req_write[wrapIdx(rrPtr_q, k)]) begin
                winFound = 1'b1;
                winId    = wrapIdx(rrPtr_q, k);
            end
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winFound && eligible[wrapIdx(rrPtr_q, k)]) begin
                winFound = 1'b1;
                winId    = wrapIdx(rrPtr_q, k);
            end
        end
    end

    // Acknowledge the granted requester in the cycle memory accepts it, and
    // steer read data to whoever sits at the head of the tag FIFO.
    always_comb begin
        reqAck    = '0;
        respValid = '0;
        if (accept) begin
            reqAck[grantId_q] = 1'b1;
        end
        if (popTag) begin
            respValid[tagMem_q[rdPtr_q]] = 1'b1;
        end
    end

    // Next occupancy of the tag FIFO; a simultaneous push and pop cancel.
    always_comb begin
        count_d = count_q;
        case ({pushTag, popTag})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Arbitration FSM: latch the winner in IDLE, hold it on the memory port in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grantId_q     <= '0;
            rrPtr_q       <= '0;
            memReqValid_q <= 1'b0;
            memReqWrite_q <= 1'b0;
            memReqAddr_q  <= '0;
            memReqWdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winFound) begin
                        grantId_q     <= winId;
                        memReqValid_q <= 1'b1;
                        memReqWrite_q <= bus.req_write[winId];
                        memReqAddr_q  <= bus.req_addr[winId];
                        memReqWdata_q <= bus.req_wdata[winId];
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        memReqValid_q <= 1'b0;
                        rrPtr_q       <= wrapIdx(grantId_q, 1);
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag FIFO of outstanding read requester IDs plus the sticky orphan flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            errOrphan_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tagMem_q[i] <= '0;
            end
        end else begin
            if (pushTag) begin
                tagMem_q[wrPtr_q] <= grantId_q;
                wrPtr_q           <= wrPtr_q + PTR_W'(1);
            end
            if (popTag) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
            if (orphanHit) begin
                errOrphan_q <= 1'b1;
            end
        end
    end

    assign bus.req_ack       = reqAck;
    assign bus.resp_valid    = respValid;
    assign bus.resp_rdata    = bus.mem_resp_rdata;
    assign bus.mem_req_valid = memReqValid_q;
    assign bus.mem_req_write = memReqWrite_q;
    assign bus.mem_req_addr  = memReqAddr_q;
    assign bus.mem_req_wdata = memReqWdata_q;
    assign bus.outstanding   = count_q;
    assign bus.err_orphan    = errOrphan_q;
endmodule
